// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the master transmit and receive engines.
//   state_t   : protocol phase of a write transfer
//   quarter_t : index of the SCL quarter inside one bit slot
//   RW_WRITE  : R/W bit value appended to the 7-bit address for a write
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  localparam logic RW_WRITE = 1'b0;

  // SCL is high during the second half of every data/ACK/STOP slot.
  function automatic logic scl_high_half(input quarter_t q);
    return (q == Q2) || (q == Q3);
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// SCL quarter-phase generator shared by the I2C master engines.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en       : run enable (engine busy); while low the phase is parked at Q0
//   tick     : high on the last clock of every quarter
//   quarter  : current quarter index Q0..Q3 within the bit slot
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int QDIV = 125
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  output logic     tick,
  output quarter_t quarter
);

  localparam logic [9:0] RELOAD = 10'(QDIV - 1);

  logic [9:0] cnt_q;

  assign tick = en && (cnt_q == '0);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q   <= RELOAD;
      quarter <= Q0;
    end else if (tick) begin
      cnt_q   <= RELOAD;
      quarter <= quarter_t'(quarter + 2'd1);
    end else begin
      cnt_q <= cnt_q - 10'd1;
    end
  end

endmodule

// File: rtl/i2c_transmit.sv
// I2C master write engine: START, 7-bit address + W, N data bytes with an
// ACK check after every byte, then STOP.
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   i2c_ready        : start request, honoured only while idle
//   i2c_dev_addr     : 7-bit slave address, latched on an accepted request
//   i2c_data_bytes   : byte count 0..15 (0 = address-only probe)
//   i2c_data         : next byte, captured in the cycle i2c_data_req is high
//   i2c_data_req     : one-cycle pulse, byte taken, upstream advances
//   i2c_scl          : push-pull SCL, idle high
//   i2c_sda          : open-drain SDA (drives 0 or z), read back for ACK
//   i2c_busy         : high for the whole transfer
//   i2c_done         : one-cycle pulse on the last clock of STOP
//   i2c_nack         : sticky slave-NACK flag, cleared by the next request
module i2c_transmit
  import i2c_pkg::*;
#(
  parameter int QDIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_ready,
  input  logic [6:0] i2c_dev_addr,
  input  logic [3:0] i2c_data_bytes,
  input  logic [7:0] i2c_data,
  output logic       i2c_data_req,
  output logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       i2c_busy,
  output logic       i2c_done,
  output logic       i2c_nack
);

  state_t     state_q, state_d;
  quarter_t   quarter;
  logic       tick;
  logic       slot_end;
  logic       accept;
  logic       sda_low;
  logic       sda_in;
  logic       shifting;
  logic       ack_slot;
  logic [7:0] shreg_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] byte_cnt_q;
  logic [3:0] count_q;

  assign i2c_busy = (state_q != IDLE);
  assign accept   = (state_q == IDLE) && i2c_ready;
  assign slot_end = tick && (quarter == Q3);
  assign shifting = (state_q == ADDR) || (state_q == DATA);
  assign ack_slot = (state_q == ADDR_ACK) || (state_q == DATA_ACK);

  // Open-drain pin: only ever pull low; the board pull-up supplies the 1.
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  assign sda_in  = i2c_sda;

  i2c_phase_gen #(.QDIV(QDIV)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .en      (i2c_busy),
    .tick    (tick),
    .quarter (quarter)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    i2c_scl      = 1'b1;
    sda_low      = 1'b0;
    i2c_data_req = 1'b0;
    i2c_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i2c_ready) state_d = START;
      end
      START: begin
        // SDA falls while SCL stays high: the START condition.
        sda_low = scl_high_half(quarter);
        if (slot_end) state_d = ADDR;
      end
      ADDR, DATA: begin
        i2c_scl = scl_high_half(quarter);
        sda_low = ~shreg_q[7];
        if (slot_end && (bit_cnt_q == 3'd7))
          state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
      end
      ADDR_ACK, DATA_ACK: begin
        i2c_scl = scl_high_half(quarter);
        // i2c_nack was updated on the last clock of Q2, so it already
        // reflects this slot's ACK by the time Q3 ends.
        if (slot_end) begin
          if (i2c_nack || (byte_cnt_q == count_q)) begin
            state_d = STOP;
          end else begin
            state_d      = DATA;
            i2c_data_req = 1'b1;
          end
        end
      end
      STOP: begin
        // SDA rises while SCL is high in Q3: the STOP condition.
        i2c_scl = scl_high_half(quarter);
        sda_low = (quarter != Q3);
        if (slot_end) begin
          state_d  = IDLE;
          i2c_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      count_q    <= '0;
      i2c_nack   <= 1'b0;
    end else begin
      if (accept) begin
        shreg_q    <= {i2c_dev_addr, RW_WRITE};
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        count_q    <= i2c_data_bytes;
        i2c_nack   <= 1'b0;
      end else if (i2c_data_req) begin
        shreg_q    <= i2c_data;
        byte_cnt_q <= byte_cnt_q + 4'd1;
      end else if (shifting && slot_end) begin
        // bit_cnt_q wraps 7->0 on its own at the end of each byte.
        shreg_q   <= {shreg_q[6:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (ack_slot && tick && (quarter == Q2) && sda_in)
        i2c_nack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_transmit.sv
// Self-checking bench for i2c_transmit. A bus monitor decodes START/STOP and
// bytes from the SCL/SDA waveform and plays an ACK/NACK-ing slave; each test
// derives the expected bus bytes, request count, NACK flag and transfer
// length from the protocol rules and compares against what was observed.
module tb_i2c_transmit;

  localparam int QDIV = 2;
  localparam int SLOT = 4 * QDIV;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i2c_ready = 1'b0;
  logic [6:0] i2c_dev_addr = '0;
  logic [3:0] i2c_data_bytes = '0;
  logic [7:0] i2c_data;
  logic       i2c_data_req;
  logic       i2c_scl;
  tri1        i2c_sda;
  logic       i2c_busy;
  logic       i2c_done;
  logic       i2c_nack;

  int n_cmp = 0;
  int n_bad = 0;

  i2c_transmit #(.QDIV(QDIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .i2c_ready      (i2c_ready),
    .i2c_dev_addr   (i2c_dev_addr),
    .i2c_data_bytes (i2c_data_bytes),
    .i2c_data       (i2c_data),
    .i2c_data_req   (i2c_data_req),
    .i2c_scl        (i2c_scl),
    .i2c_sda        (i2c_sda),
    .i2c_busy       (i2c_busy),
    .i2c_done       (i2c_done),
    .i2c_nack       (i2c_nack)
  );

  always #5 clk = ~clk;

  // ---------------- byte source ----------------
  logic [7:0]  tx_mem [0:1023];
  logic [31:0] req_total = '0;
  assign i2c_data = tx_mem[req_total[9:0]];

  always @(posedge clk) if (i2c_data_req) req_total <= req_total + 32'd1;

  // ---------------- bus monitor + slave ----------------
  bit          ack_addr_cfg = 1'b1;
  int          nack_at_cfg  = 0;
  logic        slave_low    = 1'b0;
  logic        prev_scl     = 1'b1;
  logic        prev_sda     = 1'b1;
  int          bit_idx      = 0;
  int          bytes_in_xfer = 0;
  logic [7:0]  mon_shift    = '0;
  logic [7:0]  rx_q [$];
  int          start_total  = 0;
  int          stop_total   = 0;
  int          done_total   = 0;

  assign i2c_sda = slave_low ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    logic scl_now, sda_now;
    scl_now = i2c_scl;
    sda_now = i2c_sda;
    if (i2c_done) done_total++;
    if (rst) begin
      bit_idx   = 0;
      slave_low = 1'b0;
    end else if (prev_scl && scl_now && prev_sda && !sda_now) begin
      start_total++;
      bit_idx       = 0;
      bytes_in_xfer = 0;
    end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
      stop_total++;
      bit_idx = 0;
    end else if (!prev_scl && scl_now) begin
      if (bit_idx < 8) begin
        mon_shift = {mon_shift[6:0], sda_now};
        bit_idx++;
        if (bit_idx == 8) begin
          rx_q.push_back(mon_shift);
          bytes_in_xfer++;
        end
      end else begin
        bit_idx = 9;
      end
    end else if (prev_scl && !scl_now) begin
      if (bit_idx == 8)
        slave_low = (bytes_in_xfer == 1) ? ack_addr_cfg
                                         : ((bytes_in_xfer - 1) != nack_at_cfg);
      else if (bit_idx == 9) begin
        slave_low = 1'b0;
        bit_idx   = 0;
      end
    end
    prev_scl = scl_now;
    prev_sda = sda_now;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_xfer(input logic [6:0] addr, input int n);
    @(posedge clk); #1;
    i2c_dev_addr   = addr;
    i2c_data_bytes = 4'(n);
    i2c_ready      = 1'b1;
    @(posedge clk); #1;
    i2c_ready = 1'b0;
  endtask

  // Runs one transfer and compares it against the protocol-level model:
  // k data bytes go out (all of them, fewer if the slave NACKs), the bus
  // carries {addr,W} followed by those k bytes, and the transfer lasts
  // START + 9 address slots + 9 slots per byte + STOP.
  task automatic test_transfer(input string name, input logic [6:0] addr,
                               input int n, input bit ack_addr,
                               input int nack_at, input int poke,
                               input logic [15:0][7:0] data);
    int k, exp_cycles, cycles, rx_base, req_base, done_base, start_base, stop_base;
    bit exp_nack, timed_out;
    logic [7:0] got, exp;
    exp_nack = !ack_addr || (nack_at >= 1 && nack_at <= n);
    k = !ack_addr ? 0 : ((nack_at >= 1 && nack_at <= n) ? nack_at : n);
    exp_cycles = (2 + 9 + 9 * k) * SLOT;
    for (int i = 0; i < n; i++) tx_mem[10'(req_total + 32'(i))] = data[i];
    ack_addr_cfg = ack_addr;
    nack_at_cfg  = nack_at;
    rx_base = rx_q.size();   req_base  = int'(req_total);
    done_base = done_total;  start_base = start_total; stop_base = stop_total;
    start_xfer(addr, n);
    cycles = 0;
    timed_out = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (i2c_busy !== 1'b1) begin
          n_bad++; $display("FAIL %s busy_start: got %b expected 1", name, i2c_busy);
        end
      end
      if (c == poke) begin
        i2c_ready = 1'b1; i2c_dev_addr = ~addr; i2c_data_bytes = ~4'(n);
      end
      if (c == poke + 3) i2c_ready = 1'b0;
      if (i2c_done === 1'b1) begin
        cycles = c; timed_out = 1'b0; break;
      end
    end
    i2c_ready = 1'b0;
    n_cmp++;
    if (timed_out) begin
      n_bad++; $display("FAIL %s timeout: no done within %0d cycles", name, BUDGET);
    end
    n_cmp++;
    if (cycles != exp_cycles) begin
      n_bad++; $display("FAIL %s duration: got %0d expected %0d", name, cycles, exp_cycles);
    end
    n_cmp++;
    if (rx_q.size() - rx_base != k + 1) begin
      n_bad++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, rx_q.size() - rx_base, k + 1);
    end
    for (int j = 0; j <= k; j++) begin
      got = (rx_base + j < rx_q.size()) ? rx_q[rx_base + j] : 8'hxx;
      exp = (j == 0) ? {addr, 1'b0} : data[j - 1];
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL %s bus_byte%0d: got %h expected %h", name, j, got, exp);
      end
    end
    n_cmp++;
    if (int'(req_total) - req_base != k) begin
      n_bad++;
      $display("FAIL %s data_req: got %0d expected %0d", name, int'(req_total) - req_base, k);
    end
    n_cmp++;
    if (i2c_nack !== exp_nack) begin
      n_bad++; $display("FAIL %s nack: got %b expected %b", name, i2c_nack, exp_nack);
    end
    n_cmp++;
    if (start_total - start_base != 1 || stop_total - stop_base != 1) begin
      n_bad++;
      $display("FAIL %s start_stop: got %0d/%0d expected 1/1", name,
               start_total - start_base, stop_total - stop_base);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_total - done_base != 1) begin
      n_bad++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_total - done_base);
    end
    n_cmp++;
    if (i2c_busy !== 1'b0) begin
      n_bad++; $display("FAIL %s busy_end: got %b expected 0", name, i2c_busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({i2c_scl, i2c_sda, i2c_busy, i2c_done, i2c_nack, i2c_data_req} !== 6'b110000) begin
      n_bad++;
      $display("FAIL reset_state: got scl=%b sda=%b busy=%b done=%b nack=%b req=%b expected 1 1 0 0 0 0",
               i2c_scl, i2c_sda, i2c_busy, i2c_done, i2c_nack, i2c_data_req);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_byte;
    logic [15:0][7:0] d = '0;
    d[0] = 8'hA5;
    test_transfer("single_byte", 7'h50, 1, 1'b1, 0, -1, d);
  endtask

  task automatic test_addr_nack;
    logic [15:0][7:0] d = '0;
    d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03;
    test_transfer("addr_nack", 7'h21, 3, 1'b0, 0, -1, d);
  endtask

  task automatic test_data_nack;
    logic [15:0][7:0] d = '0;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    test_transfer("data_nack", 7'h44, 3, 1'b1, 2, -1, d);
  endtask

  task automatic test_probe;
    logic [15:0][7:0] d = '0;
    test_transfer("probe", 7'h3C, 0, 1'b1, 0, -1, d);
  endtask

  task automatic test_ready_ignored;
    logic [15:0][7:0] d = '0;
    d[0] = 8'h5A; d[1] = 8'hC0;
    test_transfer("busy_ready_ignored", 7'h2A, 3, 1'b0, 0, 20, d);
    test_transfer("fresh_clears_nack", 7'h12, 2, 1'b1, 0, -1, d);
  endtask

  task automatic test_reset_mid_data;
    logic [15:0][7:0] d = '0;
    int req_base;
    tx_mem[10'(req_total)]         = 8'hC3;
    tx_mem[10'(req_total + 32'd1)] = 8'h3C;
    ack_addr_cfg = 1'b1;
    nack_at_cfg  = 0;
    req_base = int'(req_total);
    start_xfer(7'h51, 2);
    // Slot 14 is the fifth bit slot of the first data byte.
    repeat (14 * SLOT + SLOT / 2 + 1) @(negedge clk);
    n_cmp++;
    if (int'(req_total) - req_base != 1) begin
      n_bad++;
      $display("FAIL reset_mid_in_data: got %0d requests expected 1", int'(req_total) - req_base);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({i2c_scl, i2c_sda, i2c_busy, i2c_done, i2c_nack} !== 5'b11000) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got scl=%b sda=%b busy=%b done=%b nack=%b expected 1 1 0 0 0",
               i2c_scl, i2c_sda, i2c_busy, i2c_done, i2c_nack);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    d[0] = 8'h96; d[1] = 8'h69;
    test_transfer("after_reset", 7'h51, 2, 1'b1, 0, -1, d);
  endtask

  task automatic test_max_count;
    logic [15:0][7:0] d;
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
    test_transfer("max_count", 7'h7F, 15, 1'b1, 0, -1, d);
  endtask

  task automatic test_random;
    logic [15:0][7:0] d;
    int n, nack_at;
    bit ack_addr;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
      n        = int'($urandom_range(0, 6));
      ack_addr = ($urandom_range(0, 3) != 0);
      nack_at  = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
      test_transfer($sformatf("random%0d", t), 7'($urandom), n, ack_addr, nack_at, -1, d);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tx_mem[i] = '0;
    test_reset();
    test_single_byte();
    test_addr_nack();
    test_data_nack();
    test_probe();
    test_ready_ignored();
    test_reset_mid_data();
    test_max_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
